// File: rtl/fft_4_seq.sv
// fft_4_seq: 4-point radix-2 DIT FFT sequencer. It loads four complex samples,
// runs four passes through one shared external butterfly (y1 = x1 + x2,
// y2 = x1 - x2), and streams the bins out in natural order. A single 4-entry
// complex buffer holds the input, the intermediates and the results in place.
module fft_4_seq #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_r,
  input  logic [DATA_WIDTH-1:0] in_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_r,
  output logic [DATA_WIDTH-1:0] out_i,
  output logic [1:0]            out_idx,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] bf_x1_r,
  output logic [DATA_WIDTH-1:0] bf_x1_i,
  output logic [DATA_WIDTH-1:0] bf_x2_r,
  output logic [DATA_WIDTH-1:0] bf_x2_i,
  input  logic [DATA_WIDTH-1:0] bf_y1_r,
  input  logic [DATA_WIDTH-1:0] bf_y1_i,
  input  logic [DATA_WIDTH-1:0] bf_y2_r,
  input  logic [DATA_WIDTH-1:0] bf_y2_i
);

  typedef enum logic [2:0] {LOAD, BF0, BF1, BF2, BF3, OUT} state_t;

  state_t                state_reg, state_next;
  logic [1:0]            cnt_reg, cnt_next;   // input sample slot
  logic [1:0]            k_reg, k_next;       // output bin index
  logic [DATA_WIDTH-1:0] m_r [4];
  logic [DATA_WIDTH-1:0] m_i [4];
  logic [3:0]            wr_en;
  logic [DATA_WIDTH-1:0] wr_r [4];
  logic [DATA_WIDTH-1:0] wr_i [4];
  logic [1:0]            out_sel;

  // State and counter registers; reset returns to an empty LOAD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= LOAD;
      cnt_reg   <= 2'd0;
      k_reg     <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      k_reg     <= k_next;
    end
  end

  // Next-state, handshakes, butterfly operand muxing and buffer write selection.
  // Everything is forced to zero while rst_n is low.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    k_next     = k_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    bf_x1_r    = '0;
    bf_x1_i    = '0;
    bf_x2_r    = '0;
    bf_x2_i    = '0;
    wr_en      = 4'b0000;
    for (int e = 0; e < 4; e++) begin
      wr_r[e] = '0;
      wr_i[e] = '0;
    end
    if (rst_n) begin
      unique case (state_reg)
        LOAD: begin
          in_ready = 1'b1;
          if (in_valid) begin
            wr_en[cnt_reg] = 1'b1;
            wr_r[cnt_reg]  = in_r;
            wr_i[cnt_reg]  = in_i;
            cnt_next       = cnt_reg + 2'd1;
            if (cnt_reg == 2'd3) state_next = BF0;
          end
        end
        BF0: begin  // a0 = x0 + x2, a1 = x0 - x2
          busy = 1'b1;
          bf_x1_r = m_r[0]; bf_x1_i = m_i[0];
          bf_x2_r = m_r[2]; bf_x2_i = m_i[2];
          wr_en[0] = 1'b1; wr_r[0] = bf_y1_r; wr_i[0] = bf_y1_i;
          wr_en[2] = 1'b1; wr_r[2] = bf_y2_r; wr_i[2] = bf_y2_i;
          state_next = BF1;
        end
        BF1: begin  // b0 = x1 + x3, b1 = (x1 - x3) * (-j), twiddle applied on write
          busy = 1'b1;
          bf_x1_r = m_r[1]; bf_x1_i = m_i[1];
          bf_x2_r = m_r[3]; bf_x2_i = m_i[3];
          wr_en[1] = 1'b1; wr_r[1] = bf_y1_r; wr_i[1] = bf_y1_i;
          wr_en[3] = 1'b1; wr_r[3] = bf_y2_i; wr_i[3] = '0 - bf_y2_r;
          state_next = BF2;
        end
        BF2: begin  // X0 = a0 + b0, X2 = a0 - b0
          busy = 1'b1;
          bf_x1_r = m_r[0]; bf_x1_i = m_i[0];
          bf_x2_r = m_r[1]; bf_x2_i = m_i[1];
          wr_en[0] = 1'b1; wr_r[0] = bf_y1_r; wr_i[0] = bf_y1_i;
          wr_en[1] = 1'b1; wr_r[1] = bf_y2_r; wr_i[1] = bf_y2_i;
          state_next = BF3;
        end
        BF3: begin  // X1 = a1 + b1', X3 = a1 - b1'
          busy = 1'b1;
          bf_x1_r = m_r[2]; bf_x1_i = m_i[2];
          bf_x2_r = m_r[3]; bf_x2_i = m_i[3];
          wr_en[2] = 1'b1; wr_r[2] = bf_y1_r; wr_i[2] = bf_y1_i;
          wr_en[3] = 1'b1; wr_r[3] = bf_y2_r; wr_i[3] = bf_y2_i;
          state_next = OUT;
        end
        OUT: begin
          busy      = 1'b1;
          out_valid = 1'b1;
          if (out_ready) begin
            k_next = k_reg + 2'd1;
            if (k_reg == 2'd3) state_next = LOAD;
          end
        end
        default: state_next = LOAD;
      endcase
    end
  end

  // Buffer entries, each with its own write port; cleared by reset.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] r_reg, i_reg;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_reg <= '0;
          i_reg <= '0;
        end else if (wr_en[gi]) begin
          r_reg <= wr_r[gi];
          i_reg <= wr_i[gi];
        end
      end
      assign m_r[gi] = r_reg;
      assign m_i[gi] = i_reg;
    end
  endgenerate

  // Bins sit bit-reversed in the buffer: k = 0,1,2,3 lives at m[0], m[2], m[1], m[3].
  assign out_sel = {k_reg[0], k_reg[1]};
  assign out_r   = out_valid ? m_r[out_sel] : '0;
  assign out_i   = out_valid ? m_i[out_sel] : '0;
  assign out_idx = out_valid ? k_reg : 2'd0;

endmodule
